// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters,
// with registered operands/control and a registered result, one op outstanding at a time.
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int CW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_left,
   input  logic [WIDTH-1:0] req0_right,
   input  logic [CW-1:0]    req0_control,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_left,
   input  logic [WIDTH-1:0] req1_right,
   input  logic [CW-1:0]    req1_control,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_out,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_out,
   output logic [WIDTH-1:0] alu_left,
   output logic [WIDTH-1:0] alu_right,
   output logic [CW-1:0]    alu_control,
   input  logic [WIDTH-1:0] alu_out,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state;
   logic [WIDTH-1:0] op_left_p0;
   logic [WIDTH-1:0] op_right_p0;
   logic [CW-1:0]    op_control_p0;
   logic [WIDTH-1:0] result_p1;
   logic             grant_id;
   logic             last_grant;
   logic             grant_next;
   logic             accept;
   logic             rsp_done;

   // Handshake outputs are gated by rst_n so nothing is offered while reset is held.
   always_comb begin
      grant_next = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
      accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
      req0_ready = accept && !grant_next;
      req1_ready = accept && grant_next;
      rsp0_valid = rst_n && (state == RESP) && !grant_id;
      rsp1_valid = rst_n && (state == RESP) && grant_id;
      rsp_done   = (state == RESP) && (grant_id ? rsp1_ready : rsp0_ready);
      busy       = rst_n && (state != IDLE);
   end

   assign alu_left    = op_left_p0;
   assign alu_right   = op_right_p0;
   assign alu_control = op_control_p0;
   assign rsp0_out    = result_p1;
   assign rsp1_out    = result_p1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         op_left_p0    <= '0;
         op_right_p0   <= '0;
         op_control_p0 <= '0;
         result_p1     <= '0;
         grant_id      <= 1'b0;
         last_grant    <= 1'b1;
      end else begin
         case (state)
            // p0: capture the granted requester's operation
            IDLE: begin
               if (accept) begin
                  op_left_p0    <= grant_next ? req1_left    : req0_left;
                  op_right_p0   <= grant_next ? req1_right   : req0_right;
                  op_control_p0 <= grant_next ? req1_control : req0_control;
                  grant_id      <= grant_next;
                  state         <= EXEC;
               end
            end
            // p1: ALU output sampled exactly once
            EXEC: begin
               result_p1 <= alu_out;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_done) begin
                  last_grant <= grant_id;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, corner-case sequences and a
// randomized run checked against a transaction-level reference model.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_left, req0_right, req1_left, req1_right;
   logic [3:0]  req0_control, req1_control;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp0_out, rsp1_out;
   logic [31:0] alu_left, alu_right, alu_out;
   logic [3:0]  alu_control;
   logic        busy;

   int total = 0;
   int bad   = 0;

   alu_arbiter #(.WIDTH(32), .CW(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_left(req0_left),
      .req0_right(req0_right), .req0_control(req0_control),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_left(req1_left),
      .req1_right(req1_right), .req1_control(req1_control),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_out(rsp0_out),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_out(rsp1_out),
      .alu_left(alu_left), .alu_right(alu_right), .alu_control(alu_control),
      .alu_out(alu_out), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_fn(input logic [31:0] l, input logic [31:0] r,
                                          input logic [3:0] c);
      case (c)
         4'b0000: return l & r;
         4'b0001: return l | r;
         4'b0010: return l + r;
         4'b0110: return l - r;
         4'b0111: return ($signed(l) < $signed(r)) ? 32'd1 : 32'd0;
         4'b1100: return ~(l | r);
         default: return l ^ r ^ 32'hA5A5_5A5A;
      endcase
   endfunction

   assign alu_out = alu_fn(alu_left, alu_right, alu_control);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic rdy(input logic id);
      return id ? req1_ready : req0_ready;
   endfunction
   function automatic logic rvld(input logic id);
      return id ? rsp1_valid : rsp0_valid;
   endfunction
   function automatic logic [31:0] rout(input logic id);
      return id ? rsp1_out : rsp0_out;
   endfunction

   task automatic drive(input logic id, input logic v, input logic [31:0] l,
                        input logic [31:0] r, input logic [3:0] c);
      if (id) begin
         req1_valid = v; req1_left = l; req1_right = r; req1_control = c;
      end else begin
         req0_valid = v; req0_left = l; req0_right = r; req0_control = c;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // which: 0 = wait for any req ready, 1 = wait for any rsp valid (sampled on negedge)
   task automatic wait_for(input int which, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = (which == 0) ? (req0_ready || req1_ready) : (rsp0_valid || rsp1_valid);
      end
      chk(name, ok, 1'b1);
   endtask

   typedef struct {
      logic        id;
      logic [31:0] l;
      logic [31:0] r;
      logic [3:0]  c;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[8];

   // Single op with both response readies high; checks the exact accept-to-response latency.
   task automatic run_vec(input vec_t v);
      @(posedge clk); #1;
      drive(v.id, 1'b1, v.l, v.r, v.c);
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      @(negedge clk);
      chk("vec_ready", rdy(v.id), 1'b1);
      chk("vec_other_ready", rdy(!v.id), 1'b0);
      @(posedge clk); #1;
      drive(v.id, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk("vec_exec_busy", busy, 1'b1);
      chk("vec_exec_ready", rdy(v.id), 1'b0);
      chk("vec_exec_left", alu_left, v.l);
      chk("vec_exec_ctrl", {28'h0, alu_control}, {28'h0, v.c});
      chk("vec_exec_rsp", rvld(v.id), 1'b0);
      @(negedge clk);
      chk("vec_rsp_valid", rvld(v.id), 1'b1);
      chk("vec_rsp_other", rvld(!v.id), 1'b0);
      chk("vec_rsp_out", rout(v.id), v.exp);
      @(negedge clk);
      chk("vec_back_idle", busy, 1'b0);
   endtask

   bit          v[2];
   logic [31:0] ml[2], mr[2];
   logic [3:0]  mc[2];

   initial begin
      rst_n = 1'b0;
      req0_valid = 0; req1_valid = 0;
      req0_left = 0; req0_right = 0; req0_control = 0;
      req1_left = 0; req1_right = 0; req1_control = 0;
      rsp0_ready = 0; rsp1_ready = 0;

      vecs[0] = '{1'b0, 32'h45,        32'h1F,        4'b0010, 32'd100};
      vecs[1] = '{1'b1, 32'd5,         32'd30,        4'b0111, 32'd1};
      vecs[2] = '{1'b1, 32'd30,        32'd5,         4'b0111, 32'd0};
      vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'd1,         4'b0111, 32'd1};
      vecs[4] = '{1'b1, 32'd10,        32'd3,         4'b0110, 32'd7};
      vecs[5] = '{1'b0, 32'hF0,        32'h0F,        4'b0001, 32'hFF};
      vecs[6] = '{1'b0, 32'h0000_00FF, 32'h0000_0F00, 4'b1111, 32'hA5A5_55A5};
      vecs[7] = '{1'b0, 32'h0,         32'h0,         4'b1100, 32'hFFFF_FFFF};

      // Reset state, including gating of ready while a request is pending
      drive(1'b0, 1'b1, 32'h1, 32'h2, 4'h2);
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_req0_ready", req0_ready, 1'b0);
      chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
      @(posedge clk); @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_alu_left", alu_left, 32'h0);
      chk("rst_alu_right", alu_right, 32'h0);
      chk("rst_alu_ctrl", {28'h0, alu_control}, 32'h0);
      chk("rst_rsp_out", rsp0_out, 32'h0);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Tie held for four ops: grants alternate starting with requester 0
      do_reset();
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      drive(1'b0, 1'b1, 32'd1, 32'd0, 4'b0000);
      drive(1'b1, 1'b1, 32'd2, 32'd3, 4'b0010);
      for (int k = 0; k < 4; k++) begin
         logic g;
         wait_for(0, "tie_accept_timeout");
         g = req1_ready;
         chk("tie_grant", g, k % 2);
         wait_for(1, "tie_rsp_timeout");
         chk("tie_rsp_route", rsp1_valid, g);
         chk("tie_rsp_data", rout(g), g ? 32'd5 : 32'd0);
      end
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);

      // Backpressure: rsp0 held off 5 cycles while requester 1 waits
      @(posedge clk); #1;
      rsp0_ready = 1'b0;
      drive(1'b0, 1'b1, 32'd7, 32'd8, 4'b0010);
      @(negedge clk);
      chk("bp_accept", req0_ready, 1'b1);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1'b1, 1'b1, 32'd9, 32'd1, 4'b0110);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_rsp_valid", rsp0_valid, 1'b1);
         chk("bp_rsp_out", rsp0_out, 32'd15);
         chk("bp_busy", busy, 1'b1);
         chk("bp_req1_ready", req1_ready, 1'b0);
      end
      @(posedge clk); #1;
      rsp0_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", rsp0_valid, 1'b1);
      chk("bp_release_nodual", req1_ready, 1'b0);
      @(negedge clk);
      chk("bp_done_idle", req1_ready, 1'b1);
      chk("bp_done_rsp0", rsp0_valid, 1'b0);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
      wait_for(1, "bp_req1_rsp_timeout");
      chk("bp_req1_out", rsp1_out, 32'd8);
      @(negedge clk);

      // Reset while in EXEC: op discarded, tie afterwards goes to requester 0
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 32'd4, 32'd4, 4'b0010);
      @(negedge clk);
      chk("rx_accept", req1_ready, 1'b1);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1'b0, 1'b1, 32'd1, 32'd1, 4'b0010);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rx_busy", busy, 1'b0);
      chk("rx_ready", {req1_ready, req0_ready}, 2'b00);
      chk("rx_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk("rx_alu_left", alu_left, 32'h0);
      chk("rx_alu_ctrl", {28'h0, alu_control}, 32'h0);
      chk("rx_rsp_out", rsp1_out, 32'h0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rx_no_rsp", {rsp1_valid, rsp0_valid, busy}, 3'b000);
      end
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 32'd6, 32'd6, 4'b0010);
      drive(1'b1, 1'b1, 32'd2, 32'd2, 4'b0010);
      @(negedge clk);
      chk("rx_tie_req0", req0_ready, 1'b1);
      chk("rx_tie_req1", req1_ready, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
      wait_for(1, "rx_rsp_timeout");
      chk("rx_tie_out", rsp0_out, 32'd12);
      @(negedge clk);

      // Randomized traffic against a transaction-level model
      begin
         bit          outst = 1'b0;
         bit          exp_id = 1'b0;
         bit          last_m = 1'b1;
         logic [31:0] exp_out = 32'h0;
         int          done_ops = 0;
         bit          acc[2];
         do_reset();
         v[0] = 0; v[1] = 0;
         for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            acc[0] = 0; acc[1] = 0;
            if (rsp0_valid || rsp1_valid) begin
               chk("rnd_rsp_expected", outst, 1'b1);
               chk("rnd_rsp_route", {rsp1_valid, rsp0_valid}, exp_id ? 2'b10 : 2'b01);
               chk("rnd_rsp_data", rout(exp_id), exp_out);
               if (exp_id ? rsp1_ready : rsp0_ready) begin
                  outst = 0; last_m = exp_id; done_ops++;
               end
            end else if (req0_ready || req1_ready) begin
               logic g;
               g = req1_ready;
               chk("rnd_one_ready", req0_ready & req1_ready, 1'b0);
               chk("rnd_idle_accept", outst, 1'b0);
               chk("rnd_ready_valid", v[g], 1'b1);
               if (v[0] && v[1]) chk("rnd_round_robin", g, !last_m);
               outst = 1; exp_id = g; exp_out = alu_fn(ml[g], mr[g], mc[g]);
               acc[g] = 1;
            end
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
               if (acc[i]) v[i] = 0;
               if (!v[i] && $urandom_range(0, 2) != 0) begin
                  v[i] = 1; ml[i] = $urandom; mr[i] = $urandom;
                  mc[i] = 4'($urandom_range(0, 15));
               end
               drive(i[0], v[i], ml[i], mr[i], mc[i]);
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
         end
         chk("rnd_progress", done_ops >= 50, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 32-bit ALU between two requesters (e.g. the integer pipeline and a branch/address unit) with valid/ready handshakes on both the request and response sides. Grants are round-robin, and only one operation is outstanding at a time. Operands and control are registered before they drive the ALU, and the result is registered before it is returned. The block sits between the requesters and the ALU instance and does not decode opcodes.

## Interface
Parameters:
- WIDTH, 32, operand/result width (matches ALU `left`/`right`/`out`)
- CW, 4, ALU control width (matches ALU `control`)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_left / req0_right  in  WIDTH  requester 0 operands
- req0_control  in  CW  requester 0 ALU control code
- req1_valid, req1_ready, req1_left, req1_right, req1_control: same as requester 0, for requester 1
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_out  out  WIDTH  result data
- rsp1_valid, rsp1_ready, rsp1_out: same as requester 0, for requester 1
- alu_left / alu_right  out  WIDTH  to ALU `left` / `right`
- alu_control  out  CW  to ALU `control`
- alu_out  in  WIDTH  from ALU `out`
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE → EXEC → RESP → IDLE.
- **IDLE:**
  - If any reqN_valid is high, choose a grant and assert reqN_ready for that requester only, combinationally in the same cycle.
  - On the clock edge, latch that requester's left/right/control into the op registers, latch its id into grant_id, and go to EXEC.
  - If neither reqN_valid is high, stay in IDLE.
- **Arbitration:**
  - With one valid requester, grant it.
  - With both valid, grant the requester that is not last_grant.
  - last_grant updates when the FSM leaves RESP.
  - last_grant resets to 1, so requester 0 wins the first tie.
- **EXEC:** alu_left/alu_right/alu_control are driven from the op registers. On the edge, capture alu_out into result_reg and go to RESP.
- **RESP:**
  - rsp{grant_id}_valid is high; the other rspN_valid is low.
  - When the granted rspN_ready is high, go to IDLE on that edge and set last_grant = grant_id.
  - While ready is low, hold state; result_reg and the op registers stay stable.
- rsp0_out and rsp1_out are both driven from result_reg; only valid qualifies them.
- reqN_ready is low in EXEC and RESP. Requesters hold valid and data until ready.
- Control codes pass through unmodified, including codes the ALU does not implement.
- No accept in the same cycle as a response completes (RESP→IDLE first).

## Timing
- **Reset:** when rst_n is low at an edge, the FSM goes to IDLE and these registers clear:
  - op registers (alu_left, alu_right, alu_control) = 0
  - result_reg = 0
  - grant_id = 0
  - last_grant = 1
- **Outputs during reset:** busy = 0, all reqN_ready = 0, all rspN_valid = 0.
- **Latency:** accept edge T → result captured at T+1 → rspN_valid high from the cycle after T+1 (2 cycles after accept). With rsp_ready held high, the minimum cycle per op is 3.
- **Reset mid-operation (EXEC or RESP):** the op is discarded, no response is issued, and the FSM goes to IDLE the next cycle.
- **Simultaneous valid:** strictly alternate grants when both requesters stay valid.
- **Response backpressure:** stalls both requesters indefinitely; nothing is dropped.
- **Arithmetic:** the block has no arithmetic of its own; result = alu_out sampled exactly once in EXEC.

## Test plan
- **Single add:** req0 left=0x45, right=0x1F, control=0010, rsp0_ready=1.
  - req0_ready high 1 cycle.
  - rsp0_valid 2 cycles after accept with rsp0_out=100.
  - rsp1_valid stays 0.
- **SLT on requester 1:** left=5, right=30, control=0111 → rsp1_out=1. Then left=30, right=5 → 0.
- **Both valid, held 4 ops:**
  - req0 is AND 1&0 (expect 0); req1 is ADD 2+3 (expect 5).
  - Grant order 0,1,0,1.
  - Each response routed to the correct rspN with the correct data.
- **Backpressure:** hold rsp0_ready=0 for 5 cycles in RESP.
  - rsp0_valid and rsp0_out stay stable.
  - busy=1, req1_ready=0 throughout.
  - Completes on the first cycle rsp0_ready=1.
- **Reset in EXEC:** assert rst_n=0 for 1 cycle.
  - No rspN_valid ever appears for that op.
  - All outputs read their reset values.
  - A tie after reset is granted to req0.
- **Undefined control 1111:** passed unchanged on alu_control; whatever alu_out returns is delivered.
